// File: rtl/path_computation_stage.sv
// path_computation_stage: 2-deep input FIFO, XY route, flit + arbiter token issue.
// Optional PCS_PKT_COUNT_EN adds per-destination completed-flit counters.
module path_computation_stage #(
    parameter logic [3:0] ADDR = 4'b0000,
    parameter logic [2:0] ID   = 3'b000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_data,
    output logic        core_valid,
    input  logic        core_ready,
    output logic        core_ctl_valid,
    input  logic        core_ctl_ready,
    output logic [3:0]  rt_valid,
    input  logic [3:0]  rt_ready,
    output logic [3:0]  rt_ctl_valid,
    input  logic [3:0]  rt_ctl_ready,
    output logic [10:0] out_data,
    output logic [2:0]  out_ctl
`ifdef PCS_PKT_COUNT_EN
    ,
    input  logic [2:0]  cnt_sel,
    output logic [15:0] cnt_out
`endif
);

    localparam int unsigned DEPTH = 2;

    localparam logic [1:0] ADDR_X = ADDR[3:2];
    localparam logic [1:0] ADDR_Y = ADDR[1:0];

    // bit positions of the one-hot route vector
    localparam int R_N    = 0;
    localparam int R_E    = 1;
    localparam int R_S    = 2;
    localparam int R_W    = 3;
    localparam int R_CORE = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DATA,
        WAIT_CTL
    } state_t;

    state_t      state_q, state_d;

    logic [10:0] fifo_q [DEPTH];
    logic [10:0] fifo_d [DEPTH];
    logic [1:0]  count_q, count_d;
    logic        in_ready_q;

    logic [10:0] data_q, data_d;
    logic [4:0]  route_q, route_d;
    logic        dpend_q, dpend_d;
    logic        cpend_q, cpend_d;

    logic        push;
    logic        pop;
    logic        fifo_nempty;
    logic [10:0] head;
    logic [1:0]  head_x;
    logic [1:0]  head_y;
    logic [4:0]  head_route;

    logic        dsel_ready;
    logic        csel_ready;
    logic        data_hs;
    logic        ctl_hs;
    logic        done;
    logic        load;

    assign head        = fifo_q[0];
    assign head_x      = head[10:9];
    assign head_y      = head[8:7];
    assign fifo_nempty = (count_q != 2'd0);

    // in_ready is a register, so push never depends on a ready input
    assign push = in_valid && in_ready_q;
    assign pop  = load;

    // XY routing of the FIFO head: resolve X first, then Y, else local core
    always_comb begin
        head_route = 5'b00000;
        if (head_x > ADDR_X) begin
            head_route[R_E] = 1'b1;
        end else if (head_x < ADDR_X) begin
            head_route[R_W] = 1'b1;
        end else if (head_y > ADDR_Y) begin
            head_route[R_S] = 1'b1;
        end else if (head_y < ADDR_Y) begin
            head_route[R_N] = 1'b1;
        end else begin
            head_route[R_CORE] = 1'b1;
        end
    end

    // handshakes are only seen on the selected destination
    assign dsel_ready = |({core_ready, rt_ready} & route_q);
    assign csel_ready = |({core_ctl_ready, rt_ctl_ready} & route_q);
    assign data_hs    = dpend_q && dsel_ready;
    assign ctl_hs     = cpend_q && csel_ready;

    // a held flit completes when its last pending channel handshakes
    always_comb begin
        done = 1'b0;
        unique case (state_q)
            SEND:      done = data_hs && ctl_hs;
            WAIT_DATA: done = data_hs;
            WAIT_CTL:  done = ctl_hs;
            default:   done = 1'b0;
        endcase
    end

    assign load = ((state_q == IDLE) || done) && fifo_nempty;

    // FIFO next state: pop shifts the head out, push lands after the survivors
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            count_d   = count_q - 2'd1;
        end
        if (push) begin
            fifo_d[count_d[0]] = in_data;
            count_d            = count_d + 2'd1;
        end
    end

    // FIFO storage, occupancy and registered in_ready
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            in_ready_q <= (count_d < 2'd2);
        end
    end

    // output FSM: track which of data/token is still pending per flit
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        route_d = route_q;
        dpend_d = dpend_q;
        cpend_d = cpend_q;
        unique case (state_q)
            SEND: begin
                if (!done) begin
                    if (data_hs) begin
                        dpend_d = 1'b0;
                        state_d = WAIT_CTL;
                    end else if (ctl_hs) begin
                        cpend_d = 1'b0;
                        state_d = WAIT_DATA;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (done) begin
            state_d = IDLE;
            dpend_d = 1'b0;
            cpend_d = 1'b0;
        end
        if (load) begin
            state_d = SEND;
            data_d  = head;
            route_d = head_route;
            dpend_d = 1'b1;
            cpend_d = 1'b1;
        end
    end

    // output register and FSM state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            data_q  <= '0;
            route_q <= '0;
            dpend_q <= 1'b0;
            cpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            route_q <= route_d;
            dpend_q <= dpend_d;
            cpend_q <= cpend_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_data       = data_q;
    assign out_ctl        = ID;
    assign core_valid     = dpend_q && route_q[R_CORE];
    assign core_ctl_valid = cpend_q && route_q[R_CORE];
    assign rt_valid       = {4{dpend_q}} & route_q[R_W:R_N];
    assign rt_ctl_valid   = {4{cpend_q}} & route_q[R_W:R_N];

`ifdef PCS_PKT_COUNT_EN
    logic [15:0] cnt_q [5];
    logic [15:0] cnt_d [5];

    // count completed flits per destination, saturating
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            if (done && route_q[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // counter registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // counter read mux; unused selects read zero
    always_comb begin
        cnt_out = '0;
        unique case (cnt_sel)
            3'd0:    cnt_out = cnt_q[0];
            3'd1:    cnt_out = cnt_q[1];
            3'd2:    cnt_out = cnt_q[2];
            3'd3:    cnt_out = cnt_q[3];
            3'd4:    cnt_out = cnt_q[4];
            default: cnt_out = '0;
        endcase
    end
`endif

endmodule

// File: doc/path_computation_stage.md
# path_computation_stage

Clocked, synthesizable path-computation stage for one router input port. It accepts 11-bit flits from a neighbour link, buffers up to two, and computes an XY route against the node address. It then presents each flit on exactly one destination: the core-side merge or one of four router-output merges. For every flit it also issues a paired 3-bit port-ID token to that destination's input arbiter.

## Interface
Parameters:
- ADDR, 4'b0000, node address {x[3:2], y[1:0]} in a 4x4 mesh.
- ID, 3'b000, this port's ID; sent as the arbiter token.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in / out  1 / 1  link handshake.
- in_data  in  11  flit: dest_x[10:9], dest_y[8:7], payload[6:0].
- core_valid / core_ready  out / in  1 / 1  flit to node merge.
- core_ctl_valid / core_ctl_ready  out / in  1 / 1  token to the 4-input arbiter.
- rt_valid / rt_ready  out / in  4 / 4  flit to router merge d (0=N, 1=E, 2=S, 3=W).
- rt_ctl_valid / rt_ctl_ready  out / in  4 / 4  token to the 5-input arbiter for direction d.
- out_data  out  11  flit, shared by the core and all router destinations.
- out_ctl  out  3  token value; always ID.

## Operation
- Input FIFO:
  - Depth 2, with a 2-bit count.
  - in_ready = (count < 2), registered; no combinational path from any ready input.
  - Push on in_valid && in_ready.
- Route of FIFO head, decided combinationally:
  - dest_x > ADDR.x -> E.
  - dest_x < ADDR.x -> W.
  - Otherwise dest_y > ADDR.y -> S.
  - Otherwise dest_y < ADDR.y -> N.
  - Otherwise core.
- Output register holds flit, one-hot route and two flags: dpend (data pending) and cpend (token pending).
- Output FSM:
  - IDLE: no flit held. Load head if FIFO non-empty -> SEND.
  - SEND: data and token both pending.
    - Data handshake only -> WAIT_CTL.
    - Token handshake only -> WAIT_DATA.
    - Both in the same cycle -> complete.
  - WAIT_DATA / WAIT_CTL: only the remaining channel is pending; its handshake -> complete.
  - Complete: load the next head if present (stay SEND), else IDLE.
- Valids:
  - Exactly one destination's valid pair may be high, selected by route.
  - Data valid = dpend; token valid = cpend.
  - A valid, once raised, stays high with stable out_data/out_ctl until its handshake.
  - Data and token are never re-sent.
- Simultaneous FIFO push and pop: count unchanged and ordering preserved.
- Reset values:
  - count = 0, FSM = IDLE.
  - All valids 0, in_ready 1.
  - out_data = 0, out_ctl = ID.
- Reset mid-transfer: in-flight and buffered flits are discarded; no partial handshake is completed.

## Timing
- Minimum latency: flit pushed at edge E0 -> destination valids high after edge E1.
- Throughput: 1 flit/cycle when the chosen destination asserts both readies in the cycle its valids rise.
- Back-pressure: with both FIFO entries and the output register occupied, in_ready is low from the edge after the second FIFO push.
- A handshake completes at the rising edge where valid && ready.
- RESET clears all state immediately (asynchronous), with no clock required. Deassertion is released on the next CLK edge.

## Configuration
- PCS_PKT_COUNT_EN:
  - When defined, adds ports cnt_sel (in, 3) and cnt_out (out, 16).
  - Adds five 16-bit saturating counters: 0-3 router directions, 4 core.
  - A counter increments when a flit to that destination completes.
  - cnt_out = counter[cnt_sel]; cnt_sel 5-7 reads 0.
  - Counters reset to 0 and saturate at 16'hFFFF.
- When undefined, the ports and counters are absent and routing behaviour is identical.

## Test plan
- ADDR=4'b0101, flit 11'b11_01_0000001 with all readies high -> rt_valid=4'b0010 (E) one cycle after push, out_ctl=ID, out_data=11'b11_01_0000001, FSM back to IDLE next cycle.
- ADDR=4'b0101, flit dest=4'b0101 -> only core_valid and core_ctl_valid high; all rt_valid stay 0.
- rt_ctl_ready[2] held low 3 cycles while rt_ready[2]=1 for a S-bound flit -> data completes in cycle 1, token valid stays high 3 more cycles, then completes; nothing else issues meanwhile.
- Back-pressure: all readies low, push 4 flits -> flit 1 held in the output register, flits 2-3 in the FIFO, flit 4 refused (in_ready=0). Release readies -> flits 1-3 emerge in order.
- RESET asserted mid-SEND with FIFO count=2 -> all valids 0 and in_ready=1 immediately, with no clock. After release, the next flit routes normally.
- With PCS_PKT_COUNT_EN: 3 E-bound and 2 core flits -> cnt_sel=1 reads 3, cnt_sel=4 reads 2, cnt_sel=6 reads 0.
